// File: rtl/cfo_est_avg_pkg.sv
// Shared data types for the CFO estimation chain (argmax -> averager -> correction).
// BLK_LAST is the final in-block argmax count; argmax and the averager must agree on it.
package cfo_est_avg_pkg;
    localparam int THETA_W = 8;
    localparam int EPS_W   = 21;

    typedef logic [THETA_W-1:0]      theta_t;
    typedef logic signed [EPS_W-1:0] eps_t;

    localparam logic signed [9:0] BLK_LAST = 10'sd255;

    typedef struct packed {
        theta_t theta;
        eps_t   eps;
        logic   stable;
    } cfo_est_t;
endpackage

// File: rtl/cfo_out_reg.sv
// One-entry valid/ready output register. A new word arriving while an unaccepted
// word is held is dropped, and the sticky overrun flag is raised instead.
module cfo_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         overrun_o
);
    logic         valid_q, valid_d;
    logic         overrun_q, overrun_d;
    logic [W-1:0] data_q, data_d;

    // A held word may be replaced only on the cycle it is being accepted.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (load_i && (!valid_q || ready_i)) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (load_i) begin
            overrun_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign overrun_o = overrun_q;
endmodule

// File: rtl/cfo_est_avg.sv
// Averages the per-block eps decision of the argmax stage over NAVG blocks and
// hands {theta, mean eps, theta_stable} to the correction stage.
module cfo_est_avg
    import cfo_est_avg_pkg::*;
#(
    parameter int NAVG       = 4,
    parameter int CNT_W      = 10,
    localparam int LOG2_NAVG = $clog2(NAVG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [CNT_W-1:0] cnt_in,
    input  theta_t                  theta_in,
    input  eps_t                    eps_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output theta_t                  theta_o,
    output eps_t                    eps_o,
    output logic                    theta_stable,
    output logic [LOG2_NAVG:0]      blk_cnt,
    output logic                    overrun
);
    localparam int ACC_W = EPS_W + LOG2_NAVG;
    localparam int BC_W  = LOG2_NAVG + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic [0:0]              state_q, state_d;
    logic                    prev255_q;
    logic                    blk_done, capture, grp_done, first_cap;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_next;
    logic [BC_W-1:0]         blk_cnt_q, blk_cnt_d;
    theta_t                  theta_first_q, theta_first_d;
    logic                    stable_q, stable_d, stable_next;
    cfo_est_t                result, held;

    // A boundary is a 0 directly after 255; the 0 reached from warm-up (-1) is not one.
    assign blk_done  = (cnt_in == '0) && prev255_q;
    assign capture   = (state_q == ACCUM) && en && blk_done;
    assign first_cap = (blk_cnt_q == '0);
    assign grp_done  = capture && (blk_cnt_q == BC_W'(NAVG - 1));

    assign acc_next    = acc_q + ACC_W'(eps_in);
    assign stable_next = first_cap ? 1'b1 : (stable_q && (theta_in == theta_first_q));

    always_comb begin
        result.theta  = theta_in;
        result.eps    = EPS_W'(acc_next >>> LOG2_NAVG);
        result.stable = stable_next;
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        blk_cnt_d     = blk_cnt_q;
        theta_first_d = theta_first_q;
        stable_d      = stable_q;
        if (!en) begin
            state_d   = IDLE;
            acc_d     = '0;
            blk_cnt_d = '0;
            stable_d  = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = ACCUM;
        end else if (capture) begin
            stable_d      = stable_next;
            theta_first_d = first_cap ? theta_in : theta_first_q;
            if (grp_done) begin
                acc_d     = '0;
                blk_cnt_d = '0;
            end else begin
                acc_d     = acc_next;
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            prev255_q     <= 1'b0;
            acc_q         <= '0;
            blk_cnt_q     <= '0;
            theta_first_q <= '0;
            stable_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev255_q     <= (cnt_in == CNT_W'(BLK_LAST));
            acc_q         <= acc_d;
            blk_cnt_q     <= blk_cnt_d;
            theta_first_q <= theta_first_d;
            stable_q      <= stable_d;
        end
    end

    cfo_out_reg #(
        .W($bits(cfo_est_t))
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (grp_done),
        .data_i    (result),
        .ready_i   (out_ready),
        .valid_o   (out_valid),
        .data_o    (held),
        .overrun_o (overrun)
    );

    assign theta_o      = held.theta;
    assign eps_o        = held.eps;
    assign theta_stable = held.stable;
    assign blk_cnt      = blk_cnt_q;
endmodule
